// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter that commits one requester's data at a time into a shared register.
module shared_reg_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int OWNW  = $clog2(NREQ)
) (
  input  logic                  Clk,
  input  logic                  nAReset,
  input  logic                  nSClear,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*WIDTH-1:0] Din,
  output logic [NREQ-1:0]       Grant,
  output logic [NREQ-1:0]       Ack,
  output logic [WIDTH-1:0]      Dout,
  output logic [OWNW-1:0]       Owner,
  output logic                  Busy
);
  typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;
  state_t           r_state, w_state_nx;
  logic [NREQ-1:0]  r_grant, w_grant_nx, r_ack, w_ack_nx;
  logic [WIDTH-1:0] r_dout, w_dout_nx;
  logic [OWNW-1:0]  r_owner, w_owner_nx, r_gidx, w_gidx_nx, w_pick;
  int               w_best, w_dist;
  // Pick the requester closest above the last committed owner, wrapping around.
  always_comb begin
    w_pick = '0;
    w_best = NREQ;
    w_dist = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i - int'(r_owner) - 1 + NREQ) % NREQ;
      if (Req[i] && w_dist < w_best) begin
        w_best = w_dist;
        w_pick = OWNW'(i);
      end
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_ack_nx   = '0;
    w_dout_nx  = nSClear ? r_dout : '0;
    w_owner_nx = r_owner;
    w_gidx_nx  = r_gidx;
    case (r_state)
      IDLE: if (|Req) begin
        w_grant_nx = NREQ'(1) << w_pick;
        w_gidx_nx  = w_pick;
        w_state_nx = LOAD;
      end
      LOAD: if (!Req[r_gidx]) begin
        w_grant_nx = '0;
        w_state_nx = IDLE;
      end else if (nSClear) begin
        w_dout_nx  = Din[int'(r_gidx)*WIDTH +: WIDTH];
        w_owner_nx = r_gidx;
        w_ack_nx   = NREQ'(1) << r_gidx;
        w_grant_nx = '0;
        w_state_nx = ACK;
      end
      ACK:     w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge nAReset) begin
    if (!nAReset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ack   <= '0;
      r_dout  <= '0;
      r_owner <= OWNW'(NREQ-1);
      r_gidx  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_ack   <= w_ack_nx;
      r_dout  <= w_dout_nx;
      r_owner <= w_owner_nx;
      r_gidx  <= w_gidx_nx;
    end
  end
  assign Grant = r_grant;
  assign Ack   = r_ack;
  assign Dout  = r_dout;
  assign Owner = r_owner;
  assign Busy  = (r_state != IDLE);
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed stimulus, per-cycle check against a transaction-level model, plus literal spot checks.
module tb_shared_reg_arbiter;
  localparam int NREQ = 4, WIDTH = 8, OWNW = 2;
  logic Clk = 0, nAReset = 0, nSClear = 1;
  logic [NREQ-1:0] Req = '0;
  logic [NREQ*WIDTH-1:0] Din = {8'h33, 8'h22, 8'h11, 8'hA5};
  logic [NREQ-1:0] Grant, Ack;
  logic [WIDTH-1:0] Dout;
  logic [OWNW-1:0] Owner;
  logic Busy;
  int total = 0, bad = 0;
  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .Clk(Clk), .nAReset(nAReset), .nSClear(nSClear), .Req(Req), .Din(Din),
    .Grant(Grant), .Ack(Ack), .Dout(Dout), .Owner(Owner), .Busy(Busy)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask
  // Model: phase 0 = waiting, 1 = holding a grant for m_g, 2 = acknowledging m_own.
  int m_ph = 0, m_g = 0, m_own = NREQ-1;
  logic [WIDTH-1:0] m_dout = '0;
  always @(posedge Clk or negedge nAReset) begin
    if (!nAReset) begin
      m_ph = 0; m_g = 0; m_own = NREQ-1; m_dout = '0;
    end else begin
      if (!nSClear) m_dout = '0;
      if (m_ph == 2) m_ph = 0;
      else if (m_ph == 1) begin
        if (!Req[m_g]) m_ph = 0;
        else if (nSClear) begin
          m_dout = Din[m_g*WIDTH +: WIDTH];
          m_own = m_g;
          m_ph = 2;
        end
      end else if (Req != 0) begin
        for (int k = NREQ; k >= 1; k--) begin
          int idx;
          idx = (m_own + k) % NREQ;
          if (Req[idx]) m_g = idx;
        end
        m_ph = 1;
      end
    end
  end
  always @(negedge Clk) begin
    chk("m_grant", 32'(Grant), m_ph == 1 ? 32'(1) << m_g : 0);
    chk("m_ack",   32'(Ack),   m_ph == 2 ? 32'(1) << m_own : 0);
    chk("m_dout",  32'(Dout),  32'(m_dout));
    chk("m_owner", 32'(Owner), 32'(m_own));
    chk("m_busy",  32'(Busy),  32'(m_ph != 0));
  end
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  int ack_cyc[$];
  logic [NREQ-1:0] ack_seq[$];
  logic [NREQ-1:0] exp_seq [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  initial begin
    cyc(2);
    chk("rst_dout", 32'(Dout), 0);
    chk("rst_owner", 32'(Owner), 3);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_grant", 32'(Grant), 0);
    nAReset = 1;
    Req = 4'b0001;
    cyc(); chk("t1_grant", 32'(Grant), 4'b0001);
    cyc(); chk("t1_dout", 32'(Dout), 8'hA5); chk("t1_ack", 32'(Ack), 4'b0001); chk("t1_owner", 32'(Owner), 0);
    Req = 4'b0000;
    cyc(); chk("t1_ack_low", 32'(Ack), 0); chk("t1_idle", 32'(Busy), 0);
    Req = 4'b1111;
    for (int c = 1; c <= 15; c++) begin
      cyc();
      if (Ack != 0) begin
        ack_seq.push_back(Ack);
        ack_cyc.push_back(c);
        chk("t2_dout", 32'(Dout), 32'(Din[int'(Owner)*WIDTH +: WIDTH]));
      end
    end
    Req = 4'b0000;
    chk("t2_count", 32'(ack_seq.size()), 5);
    for (int i = 0; i < 5 && i < ack_seq.size(); i++) chk("t2_order", 32'(ack_seq[i]), 32'(exp_seq[i]));
    for (int i = 1; i < ack_cyc.size(); i++) chk("t2_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 3);
    cyc();
    chk("t3_owner_pre", 32'(Owner), 1);
    Req = 4'b1001;
    cyc(); chk("t3_grant", 32'(Grant), 4'b1000);
    cyc(); chk("t3_ack", 32'(Ack), 4'b1000); chk("t3_dout", 32'(Dout), 8'h33);
    Req = 4'b0001;
    cyc(2); chk("t3_grant0", 32'(Grant), 4'b0001);
    cyc(); chk("t3_ack0", 32'(Ack), 4'b0001); chk("t3_owner0", 32'(Owner), 0);
    Req = 4'b0100;
    cyc(2); chk("t4_grant", 32'(Grant), 4'b0100);
    nSClear = 0;
    cyc(); chk("t4_clr_dout", 32'(Dout), 0); chk("t4_clr_ack", 32'(Ack), 0); chk("t4_clr_grant", 32'(Grant), 4'b0100);
    cyc(); chk("t4_stall", 32'(Busy), 1); chk("t4_stall_ack", 32'(Ack), 0);
    nSClear = 1;
    cyc(); chk("t4_dout", 32'(Dout), 8'h22); chk("t4_ack", 32'(Ack), 4'b0100); chk("t4_owner", 32'(Owner), 2);
    Req = 4'b0010;
    cyc(2); chk("t5_grant", 32'(Grant), 4'b0010);
    Req = 4'b0000;
    cyc(); chk("t5_grant0", 32'(Grant), 0); chk("t5_ack", 32'(Ack), 0); chk("t5_dout", 32'(Dout), 8'h22);
    chk("t5_owner", 32'(Owner), 2); chk("t5_busy", 32'(Busy), 0);
    Req = 4'b0100;
    cyc(); chk("t6_grant", 32'(Grant), 4'b0100);
    cyc(); chk("t6_ack", 32'(Ack), 4'b0100);
    nAReset = 0;
    #1;
    chk("t6_rst_ack", 32'(Ack), 0); chk("t6_rst_dout", 32'(Dout), 0);
    chk("t6_rst_owner", 32'(Owner), 3); chk("t6_rst_busy", 32'(Busy), 0);
    nAReset = 1;
    cyc(); chk("t6_regrant", 32'(Grant), 4'b0100);
    cyc(); chk("t6_recommit", 32'(Dout), 8'h22); chk("t6_reack", 32'(Ack), 4'b0100);
    Req = 4'b0000;
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
